tx_fifo_feeder: RTL and testbench
=================================

# tx_fifo_feeder

Byte buffer and send sequencer upstream of the serial transmitter. Accepts bytes from the CPU/bus side into a DEPTH-entry FIFO. Drains them one at a time into the transmitter's `char`/`send`/`busy` handshake, so software can queue a burst without polling `busy` per character. Outputs connect directly to the transmitter's `char`, `send` and `busy` pins.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AW`, 4: pointer width, log2(DEPTH).
- `clk`  in  1  system clock (50 MHz domain shared with the transmitter).
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); one clock, no other clock domains.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe; one byte per cycle while high.
- `clr_overflow`  in  1  clears the `overflow` flag.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  AW+1  bytes currently stored (0..DEPTH).
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_char`  out  8  byte presented to the transmitter; registered.
- `tx_send`  out  1  one-cycle send request to the transmitter; registered.
- `tx_busy`  in  1  transmitter busy.

## Operation
- Storage: DEPTH×8 register array, `wr_ptr`/`rd_ptr` of AW bits wrapping modulo DEPTH, `count` register of AW+1 bits. `full`/`empty` decode `count` combinationally.
- Push: `wr_en && !full` (pre-edge `full`) writes `mem[wr_ptr]` and increments `wr_ptr`. `wr_en && full` drops the byte and sets `overflow`, even if a pop occurs the same cycle.
- Pop: occurs only in the sequencer's IDLE launch (below) and increments `rd_ptr`.
- Count: push only +1, pop only −1, both or neither unchanged.
- `overflow`: set-dominant. If a drop and `clr_overflow` coincide, it stays 1.
- Sequencer states:
  - IDLE: if `!empty && !tx_busy`, load `tx_char <= mem[rd_ptr]`, pop, `tx_send <= 1`, go SEND.
  - SEND: `tx_send <= 0`, clear guard counter, go WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`, go WAIT_DONE. Otherwise increment the 2-bit guard; when guard == 3 and still not busy, return to IDLE (byte abandoned, not re-queued).
  - WAIT_DONE: when `!tx_busy`, go IDLE.
- `tx_char` holds its last value outside launches.
- Reset (asserted at any time, including mid-transmission): state IDLE, pointers 0, count 0, `tx_send` 0, `tx_char` 0x00, `overflow` 0, guard 0. FIFO contents are discarded. Memory array contents are not reset.

## Timing
- Reset values: `full` 0, `empty` 1, `count` 0, `overflow` 0, `tx_char` 0x00, `tx_send` 0.
- A push at edge E is reflected in `count`/`empty` after E. The earliest launch decision is the cycle after E, so `tx_send` is high after edge E+1.
- `tx_send` is exactly one cycle wide per byte. It is never asserted while the state is not IDLE→SEND.
- The transmitter samples `send` at the edge ending the SEND cycle and raises `busy` the following cycle. WAIT_BUSY must see it within 3 cycles.
- Back-to-back bytes: `tx_busy` falls in cycle M → IDLE at M+1 → `tx_send` high in cycle M+2. Inter-character gap is 2 clocks of idle line beyond the stop bit.
- Throughput: one byte per transmitter frame plus 4 clocks. FIFO push bandwidth is 1 byte/clk.

## Test plan
- Single byte: push 0x41 into empty FIFO → `tx_send` high one cycle with `tx_char`=0x41. `count` goes 1→0 at launch. After the transmitter completes, state IDLE and `tx_send` stays 0.
- Burst fill: 16 consecutive pushes 0x00..0x0F while `tx_busy` held high → `count`=16 and `full`=1. A 17th push 0xFF is dropped and `overflow`=1. Releasing busy drains 0x00..0x0F in order with no 0xFF.
- Simultaneous push/pop: launch cycle coincides with `wr_en` at `count`=5 → `count` stays 5 and pointers wrap correctly across index 15→0.
- Overflow clear race: `clr_overflow` and a dropped write in the same cycle → `overflow` remains 1. `clr_overflow` alone next cycle → 0.
- Busy never asserts: hold `tx_busy`=0 after launch → return to IDLE 3 cycles into WAIT_BUSY. The next queued byte launches without loss of FIFO order.
- Reset mid-operation: assert `rst`=0 during WAIT_DONE with `count`=7 → immediately `tx_send`=0, `count`=0, `empty`=1. After release, no send until a new push.

Source files
------------

// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: byte FIFO that buffers CPU writes and feeds the serial
// transmitter one character at a time through its char/send/busy handshake.
module tx_fifo_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          clr_overflow,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_char,
  output logic          tx_send,
  input  logic          tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_char_q, tx_char_d;
  logic            tx_send_q, tx_send_d;
  logic [1:0]      guard_q, guard_d;
  logic            push, drop, pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_char  = tx_char_q;
  assign tx_send  = tx_send_q;

  // Full is judged before the edge, so a write into a full FIFO is dropped
  // even when a launch frees a slot in the same cycle.
  assign push = wr_en && !full;
  assign drop = wr_en && full;
  // The only pop: launching a byte from IDLE while the transmitter is free.
  assign pop  = (state_q == S_IDLE) && !empty && !tx_busy;

  // FIFO pointer, occupancy and sticky overflow bookkeeping
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // Set wins over clear so a drop is never lost to a coinciding clear.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Storage array; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Sequencer next state; guard counts non-busy cycles spent in WAIT_BUSY
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        guard_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          guard_d = guard_q + 1'b1;
          // Third quiet cycle: transmitter never took the byte, abandon it.
          if (guard_q == 2'd2) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer outputs: one-cycle send pulse and the launched byte
  always_comb begin
    tx_send_d = pop;
    tx_char_d = pop ? mem_q[rd_ptr_q] : tx_char_q;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_char_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_char_q  <= tx_char_d;
      tx_send_q  <= tx_send_d;
      guard_q    <= guard_d;
    end
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Bench for tx_fifo_feeder: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model with a transmitter model.
module tb_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          tx_busy = 1'b0;
  logic          full, empty, overflow, tx_send;
  logic [AW:0]   count;
  logic [7:0]    tx_char;

  tx_fifo_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_char      (tx_char),
    .tx_send      (tx_send),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: byte queue, sticky flag, last launched byte, and the
  // readiness of the sequencer derived from the handshake timing rules.
  logic [7:0] mq[$];
  bit         m_ready;
  bit         m_seen;
  int         m_k;
  int         m_low;
  bit         m_ovf;
  logic [7:0] m_char;

  // Transmitter model (drives tx_busy when auto_xmit is set)
  bit         auto_xmit = 1'b0;
  bit         xm_pending = 1'b0;
  int         xm_rem = 0;

  logic [7:0] sent_q[$];

  typedef struct {
    bit         wr;
    logic [7:0] data;
    bit         clr;
    bit         busy;
    int         e_count;
    bit         e_full;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready    = 1'b1;
    m_seen     = 1'b0;
    m_k        = 0;
    m_low      = 0;
    m_ovf      = 1'b0;
    m_char     = 8'h00;
    xm_pending = 1'b0;
    xm_rem     = 0;
  endtask

  // Apply current inputs across one clock edge and check every output.
  task automatic step();
    bit launch_exp;
    bit acc;
    bit drop;
    launch_exp = m_ready && (mq.size() > 0) && !tx_busy;
    acc        = wr_en && (mq.size() < DEPTH);
    drop       = wr_en && (mq.size() == DEPTH);
    if (launch_exp) begin
      m_char  = mq.pop_front();
      m_ready = 1'b0;
      m_seen  = 1'b0;
      m_k     = 0;
      m_low   = 0;
    end else if (!m_ready) begin
      m_k++;
      // The edge ending the send cycle does not look at busy.
      if (m_k >= 2) begin
        if (m_seen) begin
          if (!tx_busy) m_ready = 1'b1;
        end else if (tx_busy) begin
          m_seen = 1'b1;
        end else begin
          m_low++;
          if (m_low == 3) m_ready = 1'b1;
        end
      end
    end
    if (acc) mq.push_back(wr_data);
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;

    @(posedge clk);
    #1;
    chk("tx_send",  int'(tx_send),  int'(launch_exp));
    chk("tx_char",  int'(tx_char),  int'(m_char));
    chk("count",    int'(count),    mq.size());
    chk("full",     int'(full),     int'(mq.size() == DEPTH));
    chk("empty",    int'(empty),    int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (tx_send) begin
      sent_q.push_back(tx_char);
      $display("t=%0t send char=0x%02h count=%0d overflow=%0b",
               $time, tx_char, count, overflow);
    end
    if (auto_xmit) begin
      if (xm_pending) begin
        tx_busy    = 1'b1;
        xm_rem     = $urandom_range(1, 6);
        xm_pending = 1'b0;
      end else if (xm_rem > 0) begin
        xm_rem--;
        if (xm_rem == 0) tx_busy = 1'b0;
      end
    end
    if (tx_send) xm_pending = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input int max);
    int i;
    i = 0;
    while (!(mq.size() == 0 && m_ready && !tx_busy && !xm_pending && xm_rem == 0)
           && i < max) begin
      step();
      i++;
    end
    chk(name, int'(i < max), 1);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    tx_busy      = 1'b0;
    auto_xmit    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_full",     int'(full),     0);
    chk("rst_empty",    int'(empty),    1);
    chk("rst_count",    int'(count),    0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_tx_char",  int'(tx_char),  0);
    chk("rst_tx_send",  int'(tx_send),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pct[4];
    pct = '{70, 20, 50, 95};

    // Burst-fill / overflow-race table: busy held high so nothing launches.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 8'(i), 1'b0, 1'b1, i + 1, (i == 15), 1'b0};
    tbl[16] = '{1'b1, 8'hFF, 1'b1, 1'b1, 16, 1'b1, 1'b1}; // drop + clear: stays set
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b1, 1'b0}; // clear alone
    tbl[18] = '{1'b1, 8'hEE, 1'b0, 1'b1, 16, 1'b1, 1'b1}; // plain drop
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 16, 1'b1, 1'b0};

    do_reset();

    // Single byte through an empty FIFO.
    auto_xmit = 1'b1;
    push_byte(8'h41);
    chk("single_count_push", int'(count), 1);
    step();
    chk("single_send",        int'(tx_send), 1);
    chk("single_char",        int'(tx_char), 'h41);
    chk("single_count_pop",   int'(count),   0);
    step();
    chk("single_send_width",  int'(tx_send), 0);
    run_until_idle("single_idle", 50);
    repeat (5) step();

    // Burst fill, overflow race, then drain in order.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_en        = tbl[i].wr;
      wr_data      = tbl[i].data;
      clr_overflow = tbl[i].clr;
      tx_busy      = tbl[i].busy;
      step();
      chk("tbl_count", int'(count),    tbl[i].e_count);
      chk("tbl_full",  int'(full),     int'(tbl[i].e_full));
      chk("tbl_ovf",   int'(overflow), int'(tbl[i].e_ovf));
      chk("tbl_send",  int'(tx_send),  0);
    end
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    sent_q.delete();
    tx_busy   = 1'b0;
    auto_xmit = 1'b1;
    run_until_idle("drain_idle", 400);
    chk("drain_n", sent_q.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < sent_q.size()) chk("drain_order", int'(sent_q[i]), i);

    // Move pointers to 12, then straddle the 15->0 wrap with count 5 and
    // push on the launch cycle.
    for (int i = 0; i < 12; i++) push_byte(8'(8'h30 + i));
    run_until_idle("wrap_prep_idle", 300);
    auto_xmit = 1'b0;
    tx_busy   = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
    chk("wrap_count_pre", int'(count), 5);
    sent_q.delete();
    tx_busy = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    chk("wrap_send",  int'(tx_send), 1);
    chk("wrap_count", int'(count),   5);
    chk("wrap_char",  int'(tx_char), 'h50);
    auto_xmit = 1'b1;
    run_until_idle("wrap_idle", 300);
    chk("wrap_n", sent_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < sent_q.size()) chk("wrap_order", int'(sent_q[i]), 'h50 + i);

    // Transmitter never raises busy: byte abandoned, next one still launches.
    auto_xmit = 1'b0;
    tx_busy   = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    chk("abandon_first_char", int'(tx_char), 'h11);
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_send && n < 20);
    chk("abandon_gap",  n, 5);
    chk("abandon_char", int'(tx_char), 'h22);
    repeat (8) step();
    chk("abandon_empty", int'(empty), 1);

    // Reset while waiting for the transmitter to finish, count = 7.
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h60 + i));
    tx_busy = 1'b0;
    step();
    step();
    tx_busy = 1'b1;
    step();
    step();
    chk("pre_reset_count", int'(count), 7);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_send",  int'(tx_send), 0);
    chk("midrst_count", int'(count),   0);
    chk("midrst_empty", int'(empty),   1);
    chk("midrst_full",  int'(full),    0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sent_q.delete();
    repeat (3) step();
    tx_busy = 1'b0;
    repeat (10) step();
    chk("post_reset_nosend", sent_q.size(), 0);
    push_byte(8'h77);
    step();
    chk("post_reset_launch", int'(tx_send), 1);
    chk("post_reset_char",   int'(tx_char), 'h77);
    repeat (6) step();

    // Randomized traffic against the model with a responsive transmitter.
    xm_pending = 1'b0;
    auto_xmit  = 1'b1;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 250; i++) begin
        wr_en        = ($urandom_range(0, 99) < pct[blk]);
        wr_data      = 8'($urandom);
        clr_overflow = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    run_until_idle("random_idle", 2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
